// File: rtl/instr_decode_stage.sv
// instr_decode_stage: RV instruction decode with a 2-entry skid buffer.
// Fields, immediate and type are decoded on entry and held registered.
module instr_decode_stage #(
  parameter int XLEN       = 32,
  parameter int PC_W       = 32,
  parameter bit ENABLE_CSR = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decode_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] T_R   = 3'd0;
  localparam logic [2:0] T_I   = 3'd1;
  localparam logic [2:0] T_S   = 3'd2;
  localparam logic [2:0] T_B   = 3'd3;
  localparam logic [2:0] T_U   = 3'd4;
  localparam logic [2:0] T_J   = 3'd5;
  localparam logic [2:0] T_SYS = 3'd6;
  localparam logic [2:0] T_ILL = 3'd7;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
  } ent_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic              f7_ok;
  logic [2:0]        dec_type;
  logic [31:0]       imm32;
  ent_t              dec_ent;

  state_t            state_q, state_d;
  ent_t              main_q, main_d;
  ent_t              skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic              pop;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign f7_ok = (f7 == 7'h00) || (f7 == 7'h20);

  // Classify the incoming word, folding in all illegal encodings
  always_comb begin
    dec_type = T_ILL;
    unique case (1'b1)
      (opc == OPC_OP): begin
        if (f7 == 7'h00)
          dec_type = T_R;
        else if (f7 == 7'h20 &&
                 (f3 == 3'b000 || f3 == 3'b101))
          dec_type = T_R;
      end
      (opc == OPC_OPIMM): begin
        if (f3 == 3'b001)
          dec_type = (f7 == 7'h00) ? T_I : T_ILL;
        else if (f3 == 3'b101)
          dec_type = f7_ok ? T_I : T_ILL;
        else
          dec_type = T_I;
      end
      (opc == OPC_LOAD),
      (opc == OPC_JALR):   dec_type = T_I;
      (opc == OPC_STORE):  dec_type = T_S;
      (opc == OPC_BRANCH): dec_type = T_B;
      (opc == OPC_LUI),
      (opc == OPC_AUIPC):  dec_type = T_U;
      (opc == OPC_JAL):    dec_type = T_J;
      (opc == OPC_SYSTEM): begin
        if (ENABLE_CSR && f3 != 3'b100)
          dec_type = T_SYS;
      end
      default: dec_type = T_ILL;
    endcase
    if (in_instr[1:0] != 2'b11)
      dec_type = T_ILL;
  end

  // Pick the immediate for the decoded format
  always_comb begin
    imm32 = '0;
    unique case (dec_type)
      T_I: imm32 = {{20{in_instr[31]}},
                    in_instr[31:20]};
      T_S: imm32 = {{20{in_instr[31]}},
                    in_instr[31:25],
                    in_instr[11:7]};
      T_B: imm32 = {{19{in_instr[31]}},
                    in_instr[31],
                    in_instr[7],
                    in_instr[30:25],
                    in_instr[11:8],
                    1'b0};
      T_U: imm32 = {in_instr[31:12], 12'b0};
      T_J: imm32 = {{11{in_instr[31]}},
                    in_instr[31],
                    in_instr[19:12],
                    in_instr[20],
                    in_instr[30:21],
                    1'b0};
      default: imm32 = '0;
    endcase
  end

  assign dec_ent.pc    = in_pc;
  assign dec_ent.instr = in_instr;
  assign dec_ent.imm   = XLEN'($signed(imm32));
  assign dec_ent.typ   = dec_type;

  assign out_valid = (state_q != S_EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid && in_ready_q && !flush;
  assign pop       = out_valid && out_ready;

  // Skid buffer next state; in_ready depends only on the next state
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_d  = dec_ent;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && !pop) begin
          skid_d  = dec_ent;
          state_d = S_TWO;
        end else if (accept && pop) begin
          main_d  = dec_ent;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush)
      state_d = S_EMPTY;
    in_ready_d = (state_d != S_TWO);
    cnt_d      = cnt_q + (pop ? CNT_W'(1) : '0);
  end

  // State, buffer entries, in_ready and handshake counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_pc       = main_q.pc;
  assign out_opcode   = main_q.instr[6:0];
  assign out_rd       = main_q.instr[11:7];
  assign out_rs1      = main_q.instr[19:15];
  assign out_rs2      = main_q.instr[24:20];
  assign out_funct3   = main_q.instr[14:12];
  assign out_funct7   = main_q.instr[31:25];
  assign out_imm      = main_q.imm;
  assign out_type     = main_q.typ;
  assign out_illegal  = (main_q.typ == T_ILL);
  assign decode_count = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: table vectors, directed buffer sequences and
// a random scoreboard run against a queue-based decode model.
module tb_instr_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush, in_valid, in_ready;
  logic        out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_type;
  logic [15:0] decode_count;

  logic        b_flush, b_in_valid, b_in_ready;
  logic        b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_instr, b_in_pc, b_out_pc;
  logic [63:0] b_out_imm;
  logic [6:0]  b_out_opcode, b_out_funct7;
  logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
  logic [2:0]  b_out_funct3, b_out_type;
  logic [3:0]  b_decode_count;

  instr_decode_stage u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_type(out_type),
    .out_illegal(out_illegal), .decode_count(decode_count)
  );

  instr_decode_stage #(
    .XLEN(64), .PC_W(32), .ENABLE_CSR(1'b0), .CNT_W(4)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .out_opcode(b_out_opcode),
    .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
    .out_funct3(b_out_funct3), .out_funct7(b_out_funct7),
    .out_imm(b_out_imm), .out_type(b_out_type),
    .out_illegal(b_out_illegal), .decode_count(b_decode_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [63:0] v, input int b);
    logic [63:0] m;
    m = 64'd1 << b;
    if (v[b-1]) return v - m;
    return v;
  endfunction

  // Reference decode written from the encoding rules with shifts/masks
  function automatic void ref_dec(input logic [31:0] i, input bit csr,
                                  output logic [2:0] t,
                                  output logic [63:0] imm);
    logic [63:0] x;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    x  = {32'd0, i};
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    t  = 3'd7;
    imm = 64'd0;
    if (op == 7'h33) begin
      if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
        t = 3'd0;
    end else if (op == 7'h13) begin
      if (f3 == 3'd1) t = (f7 == 7'h00) ? 3'd1 : 3'd7;
      else if (f3 == 3'd5)
        t = (f7 == 7'h00 || f7 == 7'h20) ? 3'd1 : 3'd7;
      else t = 3'd1;
    end else if (op == 7'h03 || op == 7'h67) t = 3'd1;
    else if (op == 7'h23) t = 3'd2;
    else if (op == 7'h63) t = 3'd3;
    else if (op == 7'h37 || op == 7'h17) t = 3'd4;
    else if (op == 7'h6F) t = 3'd5;
    else if (op == 7'h73) t = (csr && f3 != 3'd4) ? 3'd6 : 3'd7;
    case (t)
      3'd1: imm = sx(x >> 20, 12);
      3'd2: imm = sx(((x >> 25) << 5) | ((x >> 7) & 64'd31), 12);
      3'd3: imm = sx(((x >> 31) << 12) | (((x >> 7) & 64'd1) << 11) |
                     (((x >> 25) & 64'd63) << 5) |
                     (((x >> 8) & 64'd15) << 1), 13);
      3'd4: imm = sx(x & 64'hFFFF_F000, 32);
      3'd5: imm = sx(((x >> 31) << 20) | (((x >> 12) & 64'd255) << 12) |
                     (((x >> 20) & 64'd1) << 11) |
                     (((x >> 21) & 64'd1023) << 1), 21);
      default: imm = 64'd0;
    endcase
  endfunction

  logic [6:0] opcs [11];

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    int s;
    r = $urandom;
    s = $urandom_range(0, 12);
    if (s < 11) r[6:0] = opcs[s];
    if ($urandom_range(0, 2) == 0)
      r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return r;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  t;
    logic [31:0] imm;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } txn_t;

  vec_t tv[$];
  txn_t q[$];
  int   dcnt;

  initial begin
    logic [15:0] ecnt;
    logic [2:0]  et;
    logic [63:0] eimm;
    bit          acc, pop;

    opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
             7'h37, 7'h17, 7'h6F, 7'h73, 7'h13};
    tv.push_back('{32'hFFF10093, 3'd1, 32'hFFFFFFFF});
    tv.push_back('{32'h123452B7, 3'd4, 32'h12345000});
    tv.push_back('{32'hFE208CE3, 3'd3, 32'hFFFFFFF8});
    tv.push_back('{32'h0000006F, 3'd5, 32'h00000000});
    tv.push_back('{32'h00000000, 3'd7, 32'h00000000});
    tv.push_back('{32'h40001033, 3'd7, 32'h00000000});
    tv.push_back('{32'hFE112E23, 3'd2, 32'hFFFFFFFC});
    tv.push_back('{32'h30529073, 3'd6, 32'h00000000});
    tv.push_back('{32'h00100073, 3'd6, 32'h00000000});
    tv.push_back('{32'h00004073, 3'd7, 32'h00000000});
    tv.push_back('{32'h40005013, 3'd1, 32'h00000400});
    tv.push_back('{32'h02005013, 3'd7, 32'h00000000});
    tv.push_back('{32'h00101013, 3'd1, 32'h00000001});
    tv.push_back('{32'h40000033, 3'd0, 32'h00000000});
    tv.push_back('{32'h40005033, 3'd0, 32'h00000000});
    tv.push_back('{32'h02000033, 3'd7, 32'h00000000});
    tv.push_back('{32'h800000B7, 3'd4, 32'h80000000});
    tv.push_back('{32'h0000A003, 3'd1, 32'h00000000});
    tv.push_back('{32'h00008067, 3'd1, 32'h00000000});
    tv.push_back('{32'h00000012, 3'd7, 32'h00000000});
    tv.push_back('{32'hFF9FF0EF, 3'd5, 32'hFFFFFFF8});
    tv.push_back('{32'h0040006F, 3'd5, 32'h00000004});

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    b_in_instr = '0; b_in_pc = '0;
    dcnt = 0;

    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_type", out_type, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_count", decode_count, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // single-issue table
    for (int k = 0; k < tv.size(); k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = tv[k].instr;
      in_pc = 32'h1000 + 32'(4 * k); out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_valid", k), out_valid, 1);
      chk($sformatf("tbl%0d_type", k), out_type, tv[k].t);
      chk($sformatf("tbl%0d_imm", k), out_imm, tv[k].imm);
      chk($sformatf("tbl%0d_ill", k), out_illegal, tv[k].t == 3'd7);
      chk($sformatf("tbl%0d_pc", k), out_pc, 32'h1000 + 32'(4 * k));
      chk($sformatf("tbl%0d_rd", k), out_rd, tv[k].instr[11:7]);
      chk($sformatf("tbl%0d_rs1", k), out_rs1, tv[k].instr[19:15]);
      dcnt++;
    end
    @(negedge clk);
    chk("tbl_idle", out_valid, 0);
    chk("tbl_count", decode_count, 64'(dcnt));

    // back-to-back at full rate
    in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h2000;
    @(negedge clk);
    chk("b2b_lui_type", out_type, 4);
    chk("b2b_lui_imm", out_imm, 32'h12345000);
    chk("b2b_rdy0", in_ready, 1);
    in_instr = 32'hFE208CE3; in_pc = 32'h2004;
    @(negedge clk);
    chk("b2b_beq_type", out_type, 3);
    chk("b2b_beq_imm", out_imm, 32'hFFFFFFF8);
    chk("b2b_rdy1", in_ready, 1);
    in_instr = 32'h0000006F; in_pc = 32'h2008;
    @(negedge clk);
    chk("b2b_jal_type", out_type, 5);
    chk("b2b_jal_imm", out_imm, 0);
    chk("b2b_jal_pc", out_pc, 32'h2008);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_idle", out_valid, 0);
    dcnt += 3;

    // stall with three offered instructions
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'hFFF10093; in_pc = 32'h3000;
    @(negedge clk);
    chk("stl_rdy_one", in_ready, 1);
    chk("stl_pc0", out_pc, 32'h3000);
    in_instr = 32'h123452B7; in_pc = 32'h3004;
    @(negedge clk);
    chk("stl_rdy_two", in_ready, 0);
    chk("stl_pc0_hold", out_pc, 32'h3000);
    in_instr = 32'h0000006F; in_pc = 32'h3008;
    @(negedge clk);
    chk("stl_rdy_two2", in_ready, 0);
    chk("stl_pc0_hold2", out_pc, 32'h3000);
    chk("stl_imm0_hold", out_imm, 32'hFFFFFFFF);
    chk("stl_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stl_pc1", out_pc, 32'h3004);
    chk("stl_type1", out_type, 4);
    chk("stl_rdy_back", in_ready, 1);
    @(negedge clk);
    chk("stl_pc2", out_pc, 32'h3008);
    chk("stl_type2", out_type, 5);
    in_valid = 1'b0;
    @(negedge clk);
    chk("stl_idle", out_valid, 0);
    dcnt += 3;
    chk("stl_count", decode_count, 64'(dcnt));

    // flush while full, then flush with a same-cycle pop
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'hFFF10093; in_pc = 32'h4000;
    @(negedge clk);
    in_pc = 32'h4004;
    @(negedge clk);
    chk("fl_full", in_ready, 0);
    flush = 1'b1; in_pc = 32'h4008;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_rdy", in_ready, 1);
    chk("fl_count", decode_count, 64'(dcnt));
    in_valid = 1'b1; in_pc = 32'h4010;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    dcnt++;
    chk("fl_pop_valid", out_valid, 0);
    chk("fl_pop_count", decode_count, 64'(dcnt));

    // asynchronous reset while two entries are held
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h123452B7; in_pc = 32'h5000;
    @(negedge clk);
    in_pc = 32'h5004;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_pc", out_pc, 0);
    chk("ar_imm", out_imm, 0);
    chk("ar_type", out_type, 0);
    chk("ar_count", decode_count, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("ar_rdy", in_ready, 1);
    chk("ar_valid2", out_valid, 0);

    // random traffic against the queue model
    q.delete(); ecnt = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd_count", decode_count, ecnt);
      chk("rnd_out_valid", out_valid, q.size() != 0);
      chk("rnd_in_ready", in_ready, q.size() < 2);
      if (q.size() != 0) begin
        ref_dec(q[0].instr, 1'b1, et, eimm);
        chk("rnd_pc", out_pc, q[0].pc);
        chk("rnd_type", out_type, et);
        chk("rnd_imm", out_imm, eimm[31:0]);
        chk("rnd_ill", out_illegal, et == 3'd7);
        chk("rnd_fields",
            {out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7},
            {q[0].instr[6:0], q[0].instr[11:7], q[0].instr[19:15],
             q[0].instr[24:20], q[0].instr[14:12], q[0].instr[31:25]});
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rnd_instr();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      acc = in_valid && (q.size() < 2) && !flush;
      pop = (q.size() != 0) && out_ready;
      if (pop) begin
        void'(q.pop_front());
        ecnt++;
      end
      if (flush) q.delete();
      if (acc) q.push_back('{in_instr, in_pc});
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;

    // XLEN=64, CSR disabled, 4-bit counter wrap
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("b_lui_type", b_out_type, 4);
        chk("b_lui_imm", b_out_imm, 64'hFFFFFFFF80000000);
      end
      if (k == 2) begin
        chk("b_csr_type", b_out_type, 7);
        chk("b_csr_ill", b_out_illegal, 1);
        chk("b_csr_imm", b_out_imm, 0);
      end
      b_in_valid = 1'b1;
      b_in_pc = 32'(k);
      b_in_instr = (k == 0) ? 32'h80000537 :
                   (k == 1) ? 32'h30529073 : 32'hFFF10093;
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("b_last_imm", b_out_imm, 64'hFFFFFFFFFFFFFFFF);
    @(negedge clk);
    chk("b_idle", b_out_valid, 0);
    chk("b_wrap", b_decode_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
